// File: rtl/signal_source_mux_if.sv
// Sample-path bundle between the generator bank / switches and the codec-side selector.
// The slave modport is the selector; the master modport is whatever drives sources, switches and ready.
interface signal_source_mux_if #(
    parameter int W    = 24,
    parameter int NSRC = 4
);
    localparam int IW = $clog2(NSRC + 1);

    logic [NSRC*W-1:0]   src_data;
    logic [NSRC-1:0]     sw;
    logic                ready;
    logic signed [W-1:0] l_out;
    logic signed [W-1:0] r_out;
    logic [IW-1:0]       active_idx;
    logic                busy;

    modport master (
        output src_data, sw, ready,
        input  l_out, r_out, active_idx, busy
    );

    modport slave (
        input  src_data, sw, ready,
        output l_out, r_out, active_idx, busy
    );
endinterface

// File: rtl/signal_source_mux.sv
// Debounced one-hot source selector feeding the codec, paced by the codec ready strobe.
// Define SIGNAL_SOURCE_MUX_FADE_EN for the click-free gain ramp; otherwise sources switch immediately at full gain.
module signal_source_mux #(
    parameter int W          = 24,
    parameter int NSRC       = 4,
    parameter int FADE_SHIFT = 4,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               reset,
    signal_source_mux_if.slave bus
);
    localparam int IW  = $clog2(NSRC + 1);
    localparam int DCW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int GW  = FADE_SHIFT + 1;
    localparam int PW  = W + FADE_SHIFT + 1;

    localparam logic [IW-1:0]  MUTE_IDX  = IW'(NSRC);
    localparam logic [DCW-1:0] DEB_LAST  = DCW'(DEB_CYCLES - 1);
    localparam logic [GW-1:0]  FULL_GAIN = {1'b1, {FADE_SHIFT{1'b0}}};

    logic [NSRC-1:0]     sw_meta_p0;
    logic [NSRC-1:0]     sw_sync_p1;
    logic [NSRC-1:0]     sw_stable;
    logic [DCW-1:0]      deb_cnt;
    logic [IW-1:0]       hot_cnt;
    logic [IW-1:0]       hot_idx;
    logic [IW-1:0]       target_idx;
    logic [IW-1:0]       active_idx_q;
    logic [IW-1:0]       out_idx;
    logic signed [W-1:0] sel_sample;
    logic signed [W-1:0] out_sample;
    logic signed [W-1:0] l_out_q;

    // Product is one bit wider than needed for the most negative sample at full gain, so no overflow.
    function automatic logic signed [W-1:0] scale_sample(
        input logic signed [W-1:0] sample,
        input logic [GW-1:0]       gain
    );
        logic signed [PW-1:0] prod;
        prod = PW'(sample) * $signed(PW'(gain));
        prod = prod >>> FADE_SHIFT;
        return prod[W-1:0];
    endfunction

    // ---- stage p0/p1: switch synchroniser, then debounce on the synchronised value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_meta_p0 <= '0;
            sw_sync_p1 <= '0;
            deb_cnt    <= '0;
            sw_stable  <= '0;
        end else begin
            sw_meta_p0 <= bus.sw;
            sw_sync_p1 <= sw_meta_p0;
            // Comparing the two flops looks one edge ahead, so acceptance lands 2 + DEB_CYCLES clocks after sw moves.
            if (sw_meta_p0 != sw_sync_p1) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                sw_stable <= sw_sync_p1;
            end else begin
                deb_cnt <= deb_cnt + DCW'(1);
            end
        end
    end

    always_comb begin
        hot_cnt = '0;
        hot_idx = MUTE_IDX;
        for (int i = 0; i < NSRC; i++) begin
            if (sw_stable[i]) begin
                hot_cnt = hot_cnt + IW'(1);
                hot_idx = IW'(i);
            end
        end
        target_idx = (hot_cnt == IW'(1)) ? hot_idx : MUTE_IDX;
    end

    always_comb begin
        sel_sample = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (out_idx == IW'(i)) begin
                sel_sample = bus.src_data[i*W +: W];
            end
        end
    end

`ifdef SIGNAL_SOURCE_MUX_FADE_EN
    typedef enum logic [1:0] {PLAY, FADE_OUT, SWITCH, FADE_IN} state_t;

    localparam logic [GW-1:0] PRE_FULL = FULL_GAIN - GW'(1);

    state_t          state_q;
    state_t          state_d;
    logic [GW-1:0]   gain_q;
    logic            gain_dn;
    logic            gain_up;
    logic            idx_load;
    logic            busy_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= PLAY;
        end else begin
            state_q <= state_d;
        end
    end

    // Target moves during FADE_OUT/SWITCH are simply picked up at SWITCH; only FADE_IN reverses.
    always_comb begin
        state_d = state_q;
        if (bus.ready) begin
            case (state_q)
                PLAY:     if (target_idx != active_idx_q) state_d = FADE_OUT;
                FADE_OUT: if (gain_q == '0) state_d = SWITCH;
                SWITCH:   state_d = FADE_IN;
                FADE_IN: begin
                    if (target_idx != active_idx_q) begin
                        state_d = FADE_OUT;
                    end else if (gain_q == PRE_FULL) begin
                        state_d = PLAY;
                    end
                end
                default:  state_d = PLAY;
            endcase
        end
    end

    always_comb begin
        gain_dn  = 1'b0;
        gain_up  = 1'b0;
        idx_load = 1'b0;
        busy_d   = (state_q != PLAY);
        if (bus.ready) begin
            case (state_q)
                FADE_OUT: gain_dn  = (gain_q != '0);
                SWITCH:   idx_load = 1'b1;
                FADE_IN:  gain_up  = (target_idx == active_idx_q);
                default:  ;
            endcase
        end
    end

    assign out_idx    = active_idx_q;
    assign out_sample = scale_sample(sel_sample, gain_q);
    assign bus.busy   = busy_d;

    // ---- output stage: sample uses pre-edge gain and index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gain_q       <= '0;
            active_idx_q <= MUTE_IDX;
            l_out_q      <= '0;
        end else if (bus.ready) begin
            l_out_q <= out_sample;
            if (gain_dn) begin
                gain_q <= gain_q - GW'(1);
            end else if (gain_up) begin
                gain_q <= gain_q + GW'(1);
            end
            if (idx_load) begin
                active_idx_q <= target_idx;
            end
        end
    end

    gain_in_range: assert property (@(posedge clk) disable iff (reset) gain_q <= FULL_GAIN);
`else
    assign out_idx    = target_idx;
    assign out_sample = scale_sample(sel_sample, FULL_GAIN);
    assign bus.busy   = 1'b0;

    // ---- output stage: index and sample follow the target on the same strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_idx_q <= MUTE_IDX;
            l_out_q      <= '0;
        end else if (bus.ready) begin
            active_idx_q <= target_idx;
            l_out_q      <= out_sample;
        end
    end
`endif

    idx_in_range: assert property (@(posedge clk) disable iff (reset) active_idx_q <= MUTE_IDX);

    assign bus.l_out      = l_out_q;
    assign bus.r_out      = l_out_q;
    assign bus.active_idx = active_idx_q;
endmodule
